// File: rtl/arisco_seq_pkg.sv
// arisco_seq_pkg
// Shared definitions for the instruction sequencer: the controller state
// encoding, the major opcodes the sequencer recognises, and the NOP word
// loaded into the instruction register out of reset.
package arisco_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DECODE,
    LOAD_WAIT,
    EXECUTE,
    HALT
  } seq_state_t;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/seq_pc_unit.sv
// seq_pc_unit
// Combinational PC arithmetic for the sequencer.
// Ports:
//   pc         in  32  address of the current instruction
//   is_jal     in   1  current instruction is a JAL
//   j_field    in  20  instruction[31:12], the raw J-type immediate bits
//   pc_plus4   out 32  pc + 4 (link value and sequential successor)
//   new_pc     out 32  PC to load at the end of EXECUTE
//   misaligned out  1  new_pc is not word aligned
module seq_pc_unit
  import arisco_seq_pkg::*;
(
  input  logic [31:0] pc,
  input  logic        is_jal,
  input  logic [19:0] j_field,
  output logic [31:0] pc_plus4,
  output logic [31:0] new_pc,
  output logic        misaligned
);

  logic [31:0] j_imm;

  // j_field bit k is instruction bit k+12, so the J-immediate scatter
  // {i[31], i[19:12], i[20], i[30:21], 0} maps onto the indices below.
  always_comb begin
    j_imm      = {{11{j_field[19]}}, j_field[19], j_field[7:0], j_field[8],
                  j_field[18:9], 1'b0};
    pc_plus4   = pc + 32'd4;
    new_pc     = is_jal ? (pc + j_imm) : pc_plus4;
    misaligned = (new_pc[1:0] != 2'b00);
  end

endmodule

// File: rtl/instruction_sequencer.sv
// instruction_sequencer
// Multi-cycle controller for the single-instruction datapath. Holds the PC
// and instruction register, fetches over a req/ack handshake, strobes
// exec_en for one cycle per instruction, follows JAL, and halts on SYSTEM,
// illegal opcodes or a misaligned next PC.
// Ports:
//   clk, rst_n       clock (rising edge), asynchronous active-low reset
//   run              in   level enable; leaves IDLE only while high
//   fetch_req/addr   out  fetch request and address (addr equals pc)
//   fetch_ack/data   in   fetch completion and instruction word
//   instruction      out  instruction register
//   pc, pc_next      out  current PC and pc+4
//   exec_en          out  one-cycle datapath write strobe
//   halted, fault    out  sticky halt and fault flags
//   retired_count    out  executed-instruction count (RETIRE_COUNTER_EN only)
// Optional feature macro: RETIRE_COUNTER_EN.
module instruction_sequencer
  import arisco_seq_pkg::*;
#(
  parameter logic [31:0] RESET_PC          = 32'h0000_0000,
  parameter int          FETCH_ALIGN_CHECK = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  output logic        fetch_req,
  output logic [31:0] fetch_addr,
  input  logic        fetch_ack,
  input  logic [31:0] fetch_data,
  output logic [31:0] instruction,
  output logic [31:0] pc,
  output logic [31:0] pc_next,
  output logic        exec_en,
  output logic        halted,
  output logic        fault
`ifdef RETIRE_COUNTER_EN
  ,
  output logic [31:0] retired_count
`endif
);

  seq_state_t  state_q, state_d;
  logic [6:0]  opcode;
  logic [31:0] new_pc;
  logic        misaligned;
  logic        load_ir, take_pc, set_halt, set_fault;

  assign opcode     = instruction[6:0];
  assign fetch_addr = pc;

  seq_pc_unit u_pc_unit (
    .pc         (pc),
    .is_jal     (opcode == OP_JAL),
    .j_field    (instruction[31:12]),
    .pc_plus4   (pc_next),
    .new_pc     (new_pc),
    .misaligned (misaligned)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic plus the update strobes for the architectural registers.
  always_comb begin
    state_d   = state_q;
    fetch_req = 1'b0;
    exec_en   = 1'b0;
    load_ir   = 1'b0;
    take_pc   = 1'b0;
    set_halt  = 1'b0;
    set_fault = 1'b0;
    case (state_q)
      IDLE: if (run) state_d = FETCH;
      FETCH: begin
        fetch_req = 1'b1;
        if (fetch_ack) begin
          load_ir = 1'b1;
          state_d = DECODE;
        end
      end
      DECODE: begin
        case (opcode)
          OP_LOAD: state_d = LOAD_WAIT;
          OP_LUI, OP_JAL, OP_OPIMM, OP_OP, OP_STORE: state_d = EXECUTE;
          OP_SYSTEM: begin
            state_d  = HALT;
            set_halt = 1'b1;
          end
          default: begin
            state_d   = HALT;
            set_halt  = 1'b1;
            set_fault = 1'b1;
          end
        endcase
      end
      LOAD_WAIT: state_d = EXECUTE;
      EXECUTE: begin
        exec_en = 1'b1;
        take_pc = 1'b1;
        // The PC still moves to the bad target so software can see where it went.
        if ((FETCH_ALIGN_CHECK != 0) && misaligned) begin
          state_d   = HALT;
          set_halt  = 1'b1;
          set_fault = 1'b1;
        end else if (run) begin
          state_d = FETCH;
        end else begin
          state_d = IDLE;
        end
      end
      HALT: state_d = HALT;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc          <= RESET_PC;
      instruction <= NOP_INSTR;
      halted      <= 1'b0;
      fault       <= 1'b0;
    end else begin
      if (load_ir)   instruction <= fetch_data;
      if (take_pc)   pc          <= new_pc;
      if (set_halt)  halted      <= 1'b1;
      if (set_fault) fault       <= 1'b1;
    end
  end

`ifdef RETIRE_COUNTER_EN
  // EXECUTE is never entered from HALT, so the count freezes once halted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       retired_count <= 32'd0;
    else if (exec_en) retired_count <= retired_count + 32'd1;
  end
`endif

endmodule

// File: tb/tb_instruction_sequencer.sv
// tb_instruction_sequencer
// Directed bench for instruction_sequencer. Outputs are sampled 1 time unit
// after each rising edge. Define RETIRE_COUNTER_EN to also cover retired_count.
module tb_instruction_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        run;
  logic        fetch_req;
  logic [31:0] fetch_addr;
  logic        fetch_ack;
  logic [31:0] fetch_data;
  logic [31:0] instruction;
  logic [31:0] pc;
  logic [31:0] pc_next;
  logic        exec_en;
  logic        halted;
  logic        fault;
`ifdef RETIRE_COUNTER_EN
  logic [31:0] retired_count;
`endif

  int passed = 0;
  int total  = 0;
  int failed = 0;
  logic bad;

  instruction_sequencer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .run         (run),
    .fetch_req   (fetch_req),
    .fetch_addr  (fetch_addr),
    .fetch_ack   (fetch_ack),
    .fetch_data  (fetch_data),
    .instruction (instruction),
    .pc          (pc),
    .pc_next     (pc_next),
    .exec_en     (exec_en),
    .halted      (halted),
    .fault       (fault)
`ifdef RETIRE_COUNTER_EN
    ,
    .retired_count (retired_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic r, input logic ack, input logic [31:0] data);
    run        = r;
    fetch_ack  = ack;
    fetch_data = data;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else begin
      failed = failed + 1;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reset is asserted at a falling edge and released at a later falling edge.
  task automatic resetWith(input logic r, input logic [31:0] data);
    @(negedge clk);
    rst_n = 1'b0;
    applyStimulus(r, 1'b1, data);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    applyStimulus(1'b0, 1'b0, 32'h0);
    repeat (2) tick();
    checkOutput("rst_pc", pc, 32'h0);
    checkOutput("rst_instr", instruction, 32'h0000_0013);
    checkOutput("rst_fetch_req", {31'd0, fetch_req}, 32'd0);
    checkOutput("rst_exec_en", {31'd0, exec_en}, 32'd0);
    checkOutput("rst_halted", {31'd0, halted}, 32'd0);
    checkOutput("rst_fault", {31'd0, fault}, 32'd0);
`ifdef RETIRE_COUNTER_EN
    checkOutput("rst_retired", retired_count, 32'd0);
`endif

    // addi x1,x0,5 with same-cycle ack
    applyStimulus(1'b1, 1'b1, 32'h0050_0093);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    checkOutput("e1_fetch_req", {31'd0, fetch_req}, 32'd1);
    checkOutput("e1_fetch_addr", fetch_addr, 32'h0);
    checkOutput("e1_exec_en", {31'd0, exec_en}, 32'd0);
    tick();
    checkOutput("e2_instr", instruction, 32'h0050_0093);
    checkOutput("e2_fetch_req", {31'd0, fetch_req}, 32'd0);
    checkOutput("e2_exec_en", {31'd0, exec_en}, 32'd0);
    tick();
    checkOutput("e3_exec_en", {31'd0, exec_en}, 32'd1);
    checkOutput("e3_pc", pc, 32'h0);
    checkOutput("e3_pc_next", pc_next, 32'h4);
    tick();
    checkOutput("e4_pc", pc, 32'h4);
    checkOutput("e4_fetch_req", {31'd0, fetch_req}, 32'd1);
    checkOutput("e4_fetch_addr", fetch_addr, 32'h4);
    checkOutput("e4_exec_en", {31'd0, exec_en}, 32'd0);
    tick();
    tick();
    checkOutput("e6_exec_en", {31'd0, exec_en}, 32'd1);
    tick();
    checkOutput("e7_fetch_addr", fetch_addr, 32'h8);

    // jal x0,+256 at pc 0x8
    applyStimulus(1'b1, 1'b1, 32'h1000_006F);
    tick();
    checkOutput("jal_instr", instruction, 32'h1000_006F);
    checkOutput("jal_dec_pc_next", pc_next, 32'hC);
    tick();
    checkOutput("jal_exec_en", {31'd0, exec_en}, 32'd1);
    checkOutput("jal_exec_pc_next", pc_next, 32'hC);
    tick();
    checkOutput("jal_target", fetch_addr, 32'h108);
    checkOutput("jal_fetch_req", {31'd0, fetch_req}, 32'd1);

    // lw x2,0(x0): DECODE, LOAD_WAIT, EXECUTE
    applyStimulus(1'b1, 1'b1, 32'h0000_2103);
    tick();
    tick();
    checkOutput("lw_wait_exec_en", {31'd0, exec_en}, 32'd0);
    checkOutput("lw_wait_fetch_req", {31'd0, fetch_req}, 32'd0);
    tick();
    checkOutput("lw_exec_en", {31'd0, exec_en}, 32'd1);
    applyStimulus(1'b1, 1'b0, 32'h0050_0093);
    tick();
    checkOutput("lw_next_fetch_req", {31'd0, fetch_req}, 32'd1);
    checkOutput("lw_next_addr", fetch_addr, 32'h10C);

    // Delayed ack: request must stay up and stable
    bad = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (fetch_req !== 1'b1 || fetch_addr !== 32'h10C || exec_en !== 1'b0) bad = 1'b1;
    end
    checkOutput("wait_stable", {31'd0, bad}, 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_rst_pc", pc, 32'h0);
    checkOutput("async_rst_fetch_req", {31'd0, fetch_req}, 32'd0);
    applyStimulus(1'b0, 1'b1, 32'hFFFF_FFFF);
    tick();
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    tick();
    checkOutput("idle_ack_ignored_req", {31'd0, fetch_req}, 32'd0);
    checkOutput("idle_ack_ignored_instr", instruction, 32'h0000_0013);
    checkOutput("idle_pc", pc, 32'h0);

    // ECALL halts without fault
    resetWith(1'b1, 32'h0000_0073);
    repeat (3) tick();
    checkOutput("ecall_halted", {31'd0, halted}, 32'd1);
    checkOutput("ecall_fault", {31'd0, fault}, 32'd0);
    bad = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (exec_en !== 1'b0 || fetch_req !== 1'b0) bad = 1'b1;
    end
    checkOutput("ecall_quiet", {31'd0, bad}, 32'd0);
    checkOutput("ecall_halted_hold", {31'd0, halted}, 32'd1);
    checkOutput("ecall_fault_hold", {31'd0, fault}, 32'd0);

    // Illegal opcode halts with fault
    resetWith(1'b1, 32'hFFFF_FFFF);
    repeat (3) tick();
    checkOutput("illegal_halted", {31'd0, halted}, 32'd1);
    checkOutput("illegal_fault", {31'd0, fault}, 32'd1);
    bad = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (exec_en !== 1'b0 || fetch_req !== 1'b0) bad = 1'b1;
    end
    checkOutput("illegal_quiet", {31'd0, bad}, 32'd0);
    checkOutput("illegal_halted_hold", {31'd0, halted}, 32'd1);
    checkOutput("illegal_fault_hold", {31'd0, fault}, 32'd1);

    // jal x0,-4 at pc 0 wraps to 0xFFFFFFFC, then pc+4 wraps to 0
    resetWith(1'b1, 32'hFFDF_F06F);
    repeat (3) tick();
    applyStimulus(1'b1, 1'b1, 32'h0050_0093);
    tick();
    checkOutput("wrap_jal_addr", fetch_addr, 32'hFFFF_FFFC);
    tick();
    checkOutput("wrap_pc_next", pc_next, 32'h0);
    tick();
    tick();
    checkOutput("wrap_fetch_addr", fetch_addr, 32'h0);
    checkOutput("wrap_no_fault", {31'd0, fault}, 32'd0);

    // Single step: run dropped before EXECUTE
    resetWith(1'b1, 32'h0050_0093);
    tick();
    tick();
    applyStimulus(1'b0, 1'b1, 32'h0050_0093);
    tick();
    checkOutput("step_exec_en", {31'd0, exec_en}, 32'd1);
    tick();
    checkOutput("step_idle_pc", pc, 32'h4);
    checkOutput("step_idle_req", {31'd0, fetch_req}, 32'd0);
`ifdef RETIRE_COUNTER_EN
    checkOutput("step_retired1", retired_count, 32'd1);
`endif
    tick();
    checkOutput("step_still_idle", {31'd0, fetch_req}, 32'd0);
    applyStimulus(1'b1, 1'b1, 32'h0050_0093);
    tick();
    checkOutput("resume_addr", fetch_addr, 32'h4);
    checkOutput("resume_req", {31'd0, fetch_req}, 32'd1);
    repeat (3) tick();
    checkOutput("resume_pc", pc, 32'h8);
`ifdef RETIRE_COUNTER_EN
    checkOutput("step_retired2", retired_count, 32'd2);
`endif

    // jal x0,+2 at pc 0x8 -> misaligned target 0xA
    applyStimulus(1'b1, 1'b1, 32'h0020_006F);
    repeat (3) tick();
    checkOutput("misalign_pc", pc, 32'hA);
    checkOutput("misalign_halted", {31'd0, halted}, 32'd1);
    checkOutput("misalign_fault", {31'd0, fault}, 32'd1);
    repeat (4) tick();
    checkOutput("misalign_req", {31'd0, fetch_req}, 32'd0);
`ifdef RETIRE_COUNTER_EN
    checkOutput("halt_retired_frozen", retired_count, 32'd3);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
